mmult_result_fmt: RTL and testbench

Downstream stage of the 3x3 matrix multiplier: captures the 9-entry, 17-bit result matrix when the multiplier asserts valid, then streams it out as ASCII hex text, one byte per handshake, toward the UART transmitter. Output is three text rows of three 5-digit uppercase hex entries, space-separated, each row terminated by CR LF. The block buffers one matrix and ignores new results while it is still printing.

---
 rtl/mmult_pkg.sv | 28 ++
 rtl/nibble2ascii.sv | 13 +
 rtl/mmult_result_fmt.sv | 127 ++++++++++++
 tb/tb_mmult_result_fmt.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmult_pkg.sv
// Shared constants and types for the matrix-multiplier result formatter.
// Entry geometry, ASCII control bytes and the formatter state encoding.
package mmult_pkg;

   localparam int ENTRY_W = 17;
   localparam int MAT_N   = 3;
   localparam int NENT    = MAT_N * MAT_N;
   localparam int MAT_W   = NENT * ENTRY_W;
   localparam int NDIG    = (ENTRY_W + 3) / 4;

   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIGIT,
      ST_SEP,
      ST_CR,
      ST_LF
   } fmt_state_t;

   // True for the last entry of a text row.
   function automatic logic row_end(input logic [3:0] e);
      return (int'(e) % MAT_N) == (MAT_N - 1);
   endfunction

endpackage

// File: rtl/nibble2ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit encoder.
// Zero latency, no state, no flow control.
module nibble2ascii (
   input  logic [3:0] nib_i,
   output logic [7:0] asc_o
);

   always_comb begin
      if (nib_i < 4'd10) asc_o = {4'h3, nib_i};
      else               asc_o = 8'h37 + {4'h0, nib_i};
   end

endmodule

// File: rtl/mmult_result_fmt.sv
// Captures one 3x3 result matrix and streams it as 57 bytes of hex text; first byte one cycle after capture.
// tx_valid/tx_data come from registers only and hold while tx_ready is low; new results are dropped while busy.
module mmult_result_fmt
   import mmult_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             c_valid,
   input  logic [MAT_W-1:0] c_mat,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             done
);

   fmt_state_t       state_q, state_d;
   logic [MAT_W-1:0] buf_q, buf_d;
   logic [3:0]       ent_q, ent_d;
   logic [2:0]       dig_q, dig_d;
   logic             done_q, done_d;

   logic [ENTRY_W-1:0]  ent_val;
   logic [4*NDIG-1:0]   ent_pad;
   logic [3:0]          nib;
   logic [7:0]          nib_asc;
   logic                accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
         ent_q   <= '0;
         dig_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         ent_q   <= ent_d;
         dig_q   <= dig_d;
         done_q  <= done_d;
      end
   end

   // Entry 0 sits in the most significant slice of the buffer.
   always_comb begin
      ent_val = '0;
      for (int k = 0; k < NENT; k++) begin
         if (int'(ent_q) == k) ent_val = buf_q[MAT_W-1-ENTRY_W*k -: ENTRY_W];
      end
      ent_pad = {{(4*NDIG-ENTRY_W){1'b0}}, ent_val};
      nib = '0;
      for (int j = 0; j < NDIG; j++) begin
         if (int'(dig_q) == j) nib = ent_pad[4*(NDIG-1-j) +: 4];
      end
   end

   nibble2ascii u_nib (
      .nib_i (nib),
      .asc_o (nib_asc)
   );

   assign tx_valid = (state_q != ST_IDLE);
   assign busy     = tx_valid;
   assign done     = done_q;
   assign accept   = tx_valid & tx_ready;

   always_comb begin
      tx_data = 8'h00;
      case (state_q)
         ST_DIGIT: tx_data = nib_asc;
         ST_SEP:   tx_data = ASCII_SP;
         ST_CR:    tx_data = ASCII_CR;
         ST_LF:    tx_data = ASCII_LF;
         default:  tx_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      ent_d   = ent_q;
      dig_d   = dig_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (c_valid) begin
               buf_d   = c_mat;
               ent_d   = '0;
               dig_d   = '0;
               state_d = ST_DIGIT;
            end
         end
         ST_DIGIT: begin
            if (accept) begin
               if (dig_q != 3'(NDIG-1)) dig_d = dig_q + 3'd1;
               else if (row_end(ent_q)) state_d = ST_CR;
               else                     state_d = ST_SEP;
            end
         end
         ST_SEP: begin
            if (accept) begin
               ent_d   = ent_q + 4'd1;
               dig_d   = '0;
               state_d = ST_DIGIT;
            end
         end
         ST_CR: begin
            if (accept) state_d = ST_LF;
         end
         ST_LF: begin
            if (accept) begin
               if (ent_q != 4'(NENT-1)) begin
                  ent_d   = ent_q + 4'd1;
                  dig_d   = '0;
                  state_d = ST_DIGIT;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmult_result_fmt.sv
// Directed scoreboard bench for mmult_result_fmt: stimulus queues hand-written text, a monitor pops on every accept.
module tb_mmult_result_fmt;
   import mmult_pkg::*;

   typedef struct {
      logic [7:0] b;
      bit         last;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             c_valid = 1'b0;
   logic [MAT_W-1:0] c_mat = '0;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready = 1'b1;
   logic             busy;
   logic             done;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   rdy_mode = 0;

   mmult_result_fmt dut (
      .clk      (clk),
      .reset    (reset),
      .c_valid  (c_valid),
      .c_mat    (c_mat),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_row(input string s, input bit last_row);
      exp_t it;
      for (int i = 0; i < s.len(); i++) begin
         it.b = s[i];
         it.last = 1'b0;
         sb.push_back(it);
      end
      it.b = 8'h0D; it.last = 1'b0; sb.push_back(it);
      it.b = 8'h0A; it.last = last_row; sb.push_back(it);
   endtask

   task automatic push_mat(input string r0, input string r1, input string r2);
      push_row(r0, 1'b0);
      push_row(r1, 1'b0);
      push_row(r2, 1'b1);
   endtask

   function automatic logic [MAT_W-1:0] pack(input logic [16:0] e0, input logic [16:0] e1,
                                             input logic [16:0] e2, input logic [16:0] e3,
                                             input logic [16:0] e4, input logic [16:0] e5,
                                             input logic [16:0] e6, input logic [16:0] e7,
                                             input logic [16:0] e8);
      return {e0, e1, e2, e3, e4, e5, e6, e7, e8};
   endfunction

   task automatic issue(input logic [MAT_W-1:0] m);
      c_mat = m;
      c_valid = 1'b1;
      tick();
      c_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, output int cnt);
      cnt = 0;
      while (!done && cnt < budget) begin
         tick();
         cnt++;
      end
      check({name, "_done_seen"}, {31'd0, done}, 32'd1);
   endtask

   // tx_ready pattern: always ready, or ready one cycle in three.
   initial begin : rdy_drv
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #2;
         if (rdy_mode == 0) tx_ready = 1'b1;
         else begin
            ph++;
            tx_ready = (ph % 3 == 0);
         end
      end
   end

   // Monitor: compares every accepted byte, done timing and stall stability.
   initial begin : monitor
      exp_t       it;
      bit         done_exp;
      bit         stall_prev;
      logic [7:0] held;
      done_exp = 1'b0;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            done_exp = 1'b0;
            stall_prev = 1'b0;
         end else begin
            check("done_pulse", {31'd0, done}, {31'd0, done_exp});
            done_exp = 1'b0;
            if (stall_prev && tx_valid) check("stall_hold", {24'd0, tx_data}, {24'd0, held});
            if (stall_prev) check("stall_valid", {31'd0, tx_valid}, 32'd1);
            if (tx_valid && tx_ready) begin
               check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
               if (sb.size() != 0) begin
                  it = sb.pop_front();
                  check("byte", {24'd0, tx_data}, {24'd0, it.b});
                  done_exp = it.last;
               end
            end
            stall_prev = tx_valid && !tx_ready;
            held = tx_data;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cnt;
      logic [MAT_W-1:0] m;
      // Reset state
      #1;
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'h00);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // Wrapped all-FF products, continuous ready
      m = pack(17'h0FA03, 17'h0FA03, 17'h0FA03, 17'h0FA03, 17'h0FA03,
               17'h0FA03, 17'h0FA03, 17'h0FA03, 17'h0FA03);
      push_mat("0FA03 0FA03 0FA03", "0FA03 0FA03 0FA03", "0FA03 0FA03 0FA03");
      issue(m);
      check("t1_first_valid", {31'd0, tx_valid}, 32'd1);
      check("t1_first_busy", {31'd0, busy}, 32'd1);
      check("t1_first_byte", {24'd0, tx_data}, 32'h30);
      wait_done("t1", 200, cnt);
      check("t1_done_latency", cnt, 32'd57);
      check("t1_busy_at_done", {31'd0, busy}, 32'd0);
      check("t1_sb_empty", sb.size(), 32'd0);
      tick();
      check("t1_done_one_cycle", {31'd0, done}, 32'd0);

      // Entry k = k
      m = pack(17'd0, 17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6, 17'd7, 17'd8);
      push_mat("00000 00001 00002", "00003 00004 00005", "00006 00007 00008");
      issue(m);
      wait_done("t2", 200, cnt);
      check("t2_done_latency", cnt, 32'd57);
      check("t2_sb_empty", sb.size(), 32'd0);
      tick();

      // All 1FFFF with ready one cycle in three
      rdy_mode = 1;
      m = pack(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF,
               17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
      push_mat("1FFFF 1FFFF 1FFFF", "1FFFF 1FFFF 1FFFF", "1FFFF 1FFFF 1FFFF");
      issue(m);
      wait_done("t3", 1000, cnt);
      check("t3_sb_empty", sb.size(), 32'd0);
      rdy_mode = 0;
      tick(); tick();

      // Leading digits, ignored mid-stream c_valid, restart in the done cycle
      m = pack(17'h10000, 17'h0000A, 17'h00000, 17'h12345, 17'h0ABCD,
               17'h1FFFF, 17'h00001, 17'h0F0F0, 17'h10000);
      push_mat("10000 0000A 00000", "12345 0ABCD 1FFFF", "00001 0F0F0 10000");
      issue(m);
      for (int i = 0; i < 9; i++) tick();
      c_mat = pack(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF,
                   17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
      c_valid = 1'b1;
      tick();
      c_valid = 1'b0;
      check("t4_busy_midstream", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 30; i++) tick();
      c_mat = pack(17'd8, 17'd7, 17'd6, 17'd5, 17'd4, 17'd3, 17'd2, 17'd1, 17'd0);
      c_valid = 1'b1;
      push_mat("00008 00007 00006", "00005 00004 00003", "00002 00001 00000");
      wait_done("t4a", 200, cnt);
      check("t4_busy_at_done", {31'd0, busy}, 32'd0);
      tick();
      c_valid = 1'b0;
      check("t4_restart_valid", {31'd0, tx_valid}, 32'd1);
      check("t4_restart_byte", {24'd0, tx_data}, 32'h30);
      wait_done("t4b", 200, cnt);
      check("t4b_done_latency", cnt, 32'd57);
      check("t4_sb_empty", sb.size(), 32'd0);
      tick();

      // Asynchronous reset at byte 30, then a clean stream
      m = pack(17'd0, 17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6, 17'd7, 17'd8);
      push_mat("00000 00001 00002", "00003 00004 00005", "00006 00007 00008");
      issue(m);
      for (int i = 0; i < 29; i++) tick();
      #1;
      reset = 1'b1;
      sb.delete();
      #1;
      check("t5_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_tx_data", {24'd0, tx_data}, 32'h00);
      check("t5_rst_done", {31'd0, done}, 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      check("t5_idle_after_rst", {31'd0, tx_valid}, 32'd0);
      m = pack(17'h0FA03, 17'h10000, 17'h0000A, 17'h0FA03, 17'h10000,
               17'h0000A, 17'h0FA03, 17'h10000, 17'h0000A);
      push_mat("0FA03 10000 0000A", "0FA03 10000 0000A", "0FA03 10000 0000A");
      issue(m);
      wait_done("t5", 200, cnt);
      check("t5_done_latency", cnt, 32'd57);
      check("t5_sb_empty", sb.size(), 32'd0);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
